edge_detect_sync: RTL and testbench
===================================

// Module: edge_detect_sync
// PURPOSE
//   Synchronises a slow asynchronous control level into the clock domain and emits
//   single-cycle pulses on its rising and falling edges.
//   Used by video timing generators to detect config-input changes (line doubler,
//   add line) and restart timing.
//   Per-bit; WIDTH independent lanes share one clock/reset.
// PARAMETERS
//   WIDTH        1   number of independent input lanes
//   SYNC_STAGES  2   metastability flops per lane before edge compare (legal 2..4)
//   RESET_VALUE  0   value loaded into sync chain and history flop on reset (per lane, replicated)
// PORTS
//   clock      in   1      clock; all state updates on posedge
//   reset      in   1      synchronous, active-low reset
//   async_sig  in   WIDTH  asynchronous level input(s); no timing relation to clock
//   rise       out  WIDTH  1-cycle pulse per lane on synchronised 0->1
//   fall       out  WIDTH  1-cycle pulse per lane on synchronised 1->0
//   level      out  WIDTH  synchronised level (last sync stage)
// BEHAVIOUR
//   - Reset: clock is clock; reset is reset, synchronous, active-low. While reset==0 at a
//     posedge, all sync stages and the history flop <= RESET_VALUE; rise <= 0; fall <= 0.
//     level therefore reads RESET_VALUE one cycle after reset is sampled.
//   - Pipeline per lane:
//     - s[0] <= async_sig
//     - s[i] <= s[i-1]
//     - hist <= s[SYNC_STAGES-1]
//     - rise <= s[last] & ~hist
//     - fall <= ~s[last] & hist
//     - level = s[last]
//     - rise/fall are registered; no combinational path from async_sig to outputs.
//   - Latency (SYNC_STAGES=2): input stable high before posedge k -> rise high for exactly
//     the cycle after posedge k+2 (3 edges). General: SYNC_STAGES+1 edges.
//   - Each synchronised transition yields exactly one pulse of one clock cycle; a held level
//     yields no further pulses.
//   - rise and fall are mutually exclusive per lane in any cycle.
//   - Input toggling every cycle after sync: rise and fall alternate on consecutive cycles.
//   - Input pulses shorter than one clock period may be missed; no requirement to catch them.
//   - After reset release, an input level differing from RESET_VALUE produces one edge pulse
//     (e.g. RESET_VALUE=0, input held 1 -> one rise) once the chain fills.
//   - Reset asserted mid-pulse: outputs cleared at that edge; no pulse generated during reset.
//   - Lanes fully independent; simultaneous edges on different lanes each pulse.
// TESTING
//   - Reset: reset=0 for 2 cycles, async_sig=1 -> rise=0, fall=0, level=0 throughout reset.
//   - Rise latency: reset released with input 0 for 5 cycles, then async_sig 0->1 before
//     edge k -> rise=1 only in cycle after edge k+2, fall=0, level=1 from k+2.
//   - Fall: async_sig 1->0, held 10 cycles -> single fall pulse at same latency, no rise.
//   - Fast toggle: async_sig toggles every clock for 6 cycles -> alternating rise/fall
//     pulses, never both high.
//   - Mid-op reset: reset=0 in the cycle rise would assert -> rise stays 0; after release
//     with input 1 -> exactly one rise.
//   - WIDTH=4: lanes 0 and 2 rise together, lane 3 falls -> rise=4'b0101, fall=4'b1000
//     in the same cycle.

Source files
------------

// File: rtl/edge_detect_sync.sv
// Purpose: synchronise WIDTH independent async levels and pulse once per rise/fall edge.
// Latency: SYNC_STAGES+1 clock edges from a stable input to a rise/fall pulse.
// Backpressure: none; this is a free-running level sampler with no handshake.
module edge_detect_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_sig,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] level
);

    localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VALUE}};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RST_VEC;
            end
            hist_q <= RST_VEC;
            rise   <= '0;
            fall   <= '0;
        end else begin
            sync_q[0] <= async_sig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
            // History is the previous synchronised level, so each transition pulses once.
            rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & hist_q;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_edge_detect_sync.sv
// Directed bench for edge_detect_sync: a 1-lane and a 4-lane instance share clock/reset;
// expected outputs are queued per cycle as stimulus is driven and checked at negedge.
module tb_edge_detect_sync;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] level;
        string      tag;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       a1;
    logic [3:0] a4;
    logic       rise1, fall1, level1;
    logic [3:0] rise4, fall4, level4;

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;

    exp_t q1[$];
    exp_t q4[$];

    edge_detect_sync dut1 (
        .clock     (clock),
        .reset     (reset),
        .async_sig (a1),
        .rise      (rise1),
        .fall      (fall1),
        .level     (level1)
    );

    edge_detect_sync #(.WIDTH(4)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .async_sig (a4),
        .rise      (rise4),
        .fall      (fall4),
        .level     (level4)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic push1(input int c, input logic r, input logic f, input logic l, input string tag);
        exp_t e;
        e.cyc = c; e.rise = {3'b0, r}; e.fall = {3'b0, f}; e.level = {3'b0, l}; e.tag = tag;
        q1.push_back(e);
    endtask

    task automatic push4(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] l,
                         input string tag);
        exp_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.level = l; e.tag = tag;
        q4.push_back(e);
    endtask

    // Input changes before edge k: level follows after edge k+1, one pulse after edge k+2.
    task automatic expect_trans(input int k, input logic oldv, input logic newv, input int n,
                                input string tag);
        for (int c = k; c < k + n; c++) begin
            push1(c, (c == k + 2) && newv && !oldv, (c == k + 2) && !newv && oldv,
                  (c >= k + 1) ? newv : oldv, tag);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (cyc >= 1) begin
            check("excl1", {3'b0, rise1 & fall1}, 4'b0);
            check("excl4", rise4 & fall4, 4'b0);
        end
        while (q1.size() > 0 && q1[0].cyc <= cyc) begin
            e = q1.pop_front();
            if (e.cyc < cyc) begin
                tests_run++;
                failed++;
                $display("FAIL stale1 %s cyc=%0d observed=unchecked expected_cyc=%0d", e.tag, cyc, e.cyc);
            end else begin
                check({e.tag, ".rise"},  {3'b0, rise1},  e.rise);
                check({e.tag, ".fall"},  {3'b0, fall1},  e.fall);
                check({e.tag, ".level"}, {3'b0, level1}, e.level);
            end
        end
        while (q4.size() > 0 && q4[0].cyc <= cyc) begin
            e = q4.pop_front();
            if (e.cyc < cyc) begin
                tests_run++;
                failed++;
                $display("FAIL stale4 %s cyc=%0d observed=unchecked expected_cyc=%0d", e.tag, cyc, e.cyc);
            end else begin
                check({e.tag, ".rise"},  rise4,  e.rise);
                check({e.tag, ".fall"},  fall4,  e.fall);
                check({e.tag, ".level"}, level4, e.level);
            end
        end
    end

    initial begin
        logic [0:9] tog_r;
        logic [0:9] tog_f;
        logic [0:9] tog_l;
        logic       tog_in;

        // Reset held for edges 1 and 2 with inputs already high.
        reset = 1'b0;
        a1    = 1'b1;
        a4    = 4'b1000;
        push1(1, 0, 0, 0, "reset");
        push1(2, 0, 0, 0, "reset");
        push4(1, 4'b0, 4'b0, 4'b0, "w4_reset");
        push4(2, 4'b0, 4'b0, 4'b0, "w4_reset");
        // Lane 3 held high through reset produces one rise once the chain fills.
        push4(3, 4'b0, 4'b0, 4'b0, "w4_fill");
        push4(4, 4'b0, 4'b0, 4'b1000, "w4_fill");
        push4(5, 4'b1000, 4'b0, 4'b1000, "w4_fill");
        push4(6, 4'b0, 4'b0, 4'b1000, "w4_fill");
        push4(7, 4'b0, 4'b0, 4'b1000, "w4_fill");
        step(2);

        // Release with input low for 5 cycles.
        reset = 1'b1;
        a1    = 1'b0;
        expect_trans(3, 0, 0, 5, "idle");
        step(5);

        // Rise latency; lanes 0 and 2 rise while lane 3 falls on the wide instance.
        a1 = 1'b1;
        a4 = 4'b0101;
        expect_trans(8, 0, 1, 7, "rise");
        push4(8,  4'b0,    4'b0,    4'b1000, "w4_mix");
        push4(9,  4'b0,    4'b0,    4'b0101, "w4_mix");
        push4(10, 4'b0101, 4'b1000, 4'b0101, "w4_mix");
        push4(11, 4'b0,    4'b0,    4'b0101, "w4_mix");
        push4(12, 4'b0,    4'b0,    4'b0101, "w4_mix");
        step(7);

        // Fall, held 10 cycles.
        a1 = 1'b0;
        expect_trans(15, 1, 0, 10, "fall");
        step(10);

        // Toggle every clock for 6 cycles, then hold low.
        tog_r = 10'b0010101000;
        tog_f = 10'b0001010100;
        tog_l = 10'b0101010000;
        for (int i = 0; i < 10; i++) begin
            push1(25 + i, tog_r[i], tog_f[i], tog_l[i], "toggle");
        end
        tog_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a1 = tog_in;
            tog_in = ~tog_in;
            step(1);
        end
        a1 = 1'b0;
        step(4);

        // Reset lands on the edge where rise would have asserted.
        a1 = 1'b1;
        push1(35, 0, 0, 0, "midrst");
        push1(36, 0, 0, 1, "midrst");
        push1(37, 0, 0, 0, "midrst");
        step(2);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        expect_trans(38, 0, 1, 8, "post_rst");
        step(8);

        for (int i = 0; i < 20 && (q1.size() > 0 || q4.size() > 0); i++) begin
            @(negedge clock);
        end
        if (q1.size() > 0 || q4.size() > 0) begin
            tests_run++;
            failed++;
            $display("FAIL drain observed=%0d pending expected=0 pending", q1.size() + q4.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
